// File: rtl/nand_tt_sequencer.sv
// nand_tt_sequencer: sweeps the four ab input vectors into a 2-input gate, samples its output
// after a settle delay and compares each sample against an expected truth table.
module nand_tt_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  input  logic       s_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch,
  output logic [3:0] sample
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);
  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_exp;
  logic [3:0] w_onehot;
  logic [3:0] w_mis_next;
  logic [3:0] w_smp_next;
  logic [1:0] w_idx_next;
  always_comb begin
    w_onehot   = 4'b0001 << r_idx;
    w_mis_next = (mismatch & ~w_onehot) | ({4{s_in ^ r_exp[r_idx]}} & w_onehot);
    w_smp_next = (sample & ~w_onehot) | ({4{s_in}} & w_onehot);
    w_idx_next = r_idx + 2'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= 8'd0;
      r_exp    <= 4'd0;
      a_out    <= 1'b0;
      b_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= 4'd0;
      sample   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start && !abort) begin
          r_exp          <= expected;
          r_idx          <= 2'd0;
          {a_out, b_out} <= 2'b00;
          r_cnt          <= CNT_LOAD;
          pass           <= 1'b0;
          mismatch       <= 4'd0;
          sample         <= 4'd0;
          busy           <= 1'b1;
          r_state        <= SETTLE;
        end
        SETTLE: if (abort) begin
          {a_out, b_out} <= 2'b00;
          busy           <= 1'b0;
          pass           <= 1'b0;
          r_state        <= IDLE;
        end else if (r_cnt <= 8'd1) begin
          r_state <= SAMPLE;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
        SAMPLE: if (abort) begin
          {a_out, b_out} <= 2'b00;
          busy           <= 1'b0;
          pass           <= 1'b0;
          r_state        <= IDLE;
        end else begin
          sample   <= w_smp_next;
          mismatch <= w_mis_next;
          // the final vector's result is folded into pass on the same edge it is sampled
          if (r_idx == 2'd3) begin
            {a_out, b_out} <= 2'b00;
            done           <= 1'b1;
            pass           <= (w_mis_next == 4'd0);
            r_state        <= FINISH;
          end else begin
            r_idx          <= w_idx_next;
            {a_out, b_out} <= w_idx_next;
            r_cnt          <= CNT_LOAD;
            r_state        <= SETTLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nand_tt_sequencer.sv
// tb_nand_tt_sequencer: directed checks of the truth-table sequencer with a settle of 1 and of 3 cycles.
module tb_nand_tt_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, gmode = 1'b0;
  logic [3:0] expected = 4'd0;
  logic s_in, a_out, b_out, busy, done, pass;
  logic [3:0] mismatch, sample;
  logic start3 = 1'b0, abort3 = 1'b0;
  logic [3:0] expected3 = 4'd0;
  logic s_in3, a_out3, b_out3, busy3, done3, pass3;
  logic [3:0] mismatch3, sample3;
  int n_chk = 0, n_ok = 0;
  int at, nd, first, second;
  assign s_in  = gmode ? (a_out & b_out) : ~(a_out & b_out);
  assign s_in3 = ~(a_out3 & b_out3);
  always #5 clk = ~clk;
  nand_tt_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected), .s_in(s_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .sample(sample)
  );
  nand_tt_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .expected(expected3), .s_in(s_in3),
    .a_out(a_out3), .b_out(b_out3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch(mismatch3), .sample(sample3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // one sweep on the settle-1 instance; cycle i=1 is the first cycle after the start edge
  task automatic sweep(input logic [3:0] exp, output int done_at, output int n_done);
    done_at = 0;
    n_done  = 0;
    @(negedge clk);
    start    = 1'b1;
    expected = exp;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) chk("busy_first", busy, 1);
      if (i <= 8) chk("ab_vec", {a_out, b_out}, 32'((i - 1) / 2));
      if (done) begin
        n_done++;
        done_at = i;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_outs", {busy, done, pass, a_out, b_out, mismatch, sample}, 0);
    chk("rst_outs3", {busy3, done3, pass3, a_out3, b_out3, mismatch3, sample3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(4'b0111, at, nd);
    chk("nand_done_at", at, 9);
    chk("nand_done_cnt", nd, 1);
    chk("nand_pass", pass, 1);
    chk("nand_mis", mismatch, 4'b0000);
    chk("nand_smp", sample, 4'b0111);
    chk("nand_idle_busy", busy, 0);
    gmode = 1'b1;
    sweep(4'b0111, at, nd);
    chk("and_done_at", at, 9);
    chk("and_done_cnt", nd, 1);
    chk("and_smp", sample, 4'b1000);
    chk("and_mis", mismatch, 4'b1111);
    chk("and_pass", pass, 0);
    repeat (5) @(negedge clk);
    chk("hold_smp", sample, 4'b1000);
    chk("hold_mis", mismatch, 4'b1111);
    gmode = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    expected = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {busy, done, pass, a_out, b_out, mismatch, sample}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    sweep(4'b0111, at, nd);
    chk("rst_sweep_done_at", at, 9);
    chk("rst_sweep_pass", pass, 1);
    chk("rst_sweep_smp", sample, 4'b0111);
    @(negedge clk);
    start    = 1'b1;
    expected = 4'b0111;
    first    = 0;
    second   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    start = 1'b0;
    chk("hold_first_done", first, 9);
    chk("hold_period", second - first, 10);
    at = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("hold_end_idle", busy, 0);
    @(negedge clk);
    start3    = 1'b1;
    expected3 = 4'b0111;
    @(negedge clk);
    start3 = 1'b0;
    at = 0;
    nd = 0;
    for (int i = 1; i <= 26; i++) begin
      if (i <= 16) chk("s3_ab_vec", {a_out3, b_out3}, 32'((i - 1) / 4));
      start3 = (i == 7);
      if (done3) begin
        nd++;
        at = i;
      end
      @(negedge clk);
    end
    chk("s3_done_at", at, 17);
    chk("s3_done_cnt", nd, 1);
    chk("s3_pass", pass3, 1);
    chk("s3_idle", busy3, 0);
    @(negedge clk);
    start3    = 1'b1;
    expected3 = 4'b0110;
    @(negedge clk);
    start3 = 1'b0;
    repeat (5) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    chk("abort_busy", busy3, 0);
    chk("abort_ab", {a_out3, b_out3}, 0);
    chk("abort_pass", pass3, 0);
    chk("abort_smp", sample3, 4'b0001);
    chk("abort_mis", mismatch3, 4'b0001);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done3 || busy3) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
